// File: rtl/rx_frontend_mc_pkg.sv
// Shared definitions for the multichannel RX frontend: settings layout and
// saturating arithmetic helpers.
package rx_frontend_mc_pkg;

    localparam int unsigned REG_IQ_MAP   = 0;
    localparam int unsigned REG_OFFSET_I = 1;
    localparam int unsigned REG_OFFSET_Q = 2;
    localparam int unsigned REG_HET_DIR  = 3;

    localparam int unsigned IQ_SWAP        = 0;
    localparam int unsigned IQ_REAL        = 1;
    localparam int unsigned IQ_INV_Q       = 2;
    localparam int unsigned IQ_INV_I       = 3;
    localparam int unsigned IQ_DOWNCONVERT = 4;
    localparam int unsigned IQ_BYPASS      = 7;

    localparam int unsigned OFF_FIXED = 31;
    localparam int unsigned OFF_SET   = 30;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x,
                                                   input int unsigned w);
        return sat(-x, w);
    endfunction

endpackage

// File: rtl/rx_frontend_mc_chan.sv
// One RX frontend channel: settings decode for its address window, I/Q mapping,
// DC-offset correction and Fs/4 rotation, three registered stages.
module rx_frontend_mc_chan
    import rx_frontend_mc_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DC_SHIFT  = 20,
    parameter int unsigned SR_BASE   = 0,
    parameter int unsigned SR_STRIDE = 8,
    parameter int unsigned CHAN      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [2:0]       stage_en,
    input  logic [1:0]       phase,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] in_q,
    output logic [WIDTH-1:0] out_i,
    output logic [WIDTH-1:0] out_q
);

    localparam int unsigned ACC_W = WIDTH + DC_SHIFT;
    localparam int unsigned WIN   = SR_BASE + CHAN * SR_STRIDE;

    function automatic logic signed [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] x);
        return WIDTH'(sat_neg(64'(x), WIDTH));
    endfunction

    function automatic logic signed [WIDTH-1:0] dc_out(input logic signed [WIDTH-1:0] x,
                                                       input logic signed [ACC_W-1:0] acc);
        logic signed [WIDTH-1:0] off;
        off = WIDTH'(acc >>> DC_SHIFT);
        return WIDTH'(sat(64'(x) - 64'(off), WIDTH));
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] acc,
                                                        input logic signed [WIDTH-1:0] y);
        return ACC_W'(sat(64'(acc) + 64'(y), ACC_W));
    endfunction

    logic hit_map, hit_off_i, hit_off_q, hit_dir;
    logic [7:0]  iq_map;
    logic        het_dir;
    logic        off_wr_i, off_wr_q;
    logic [31:0] off_data;
    logic        fixed_i, fixed_q;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic        unused_bits;

    always_comb begin
        hit_map   = set_stb && (32'(set_addr) == WIN + REG_IQ_MAP);
        hit_off_i = set_stb && (32'(set_addr) == WIN + REG_OFFSET_I);
        hit_off_q = set_stb && (32'(set_addr) == WIN + REG_OFFSET_Q);
        hit_dir   = set_stb && (32'(set_addr) == WIN + REG_HET_DIR);
    end

    assign unused_bits = ^{off_data, iq_map[6:5]};

    // Offset writes are applied one cycle late so the sample accepted in the
    // write cycle still sees the old offset when it reaches the DC stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            iq_map   <= '0;
            het_dir  <= 1'b0;
            off_wr_i <= 1'b0;
            off_wr_q <= 1'b0;
            off_data <= '0;
        end else begin
            if (hit_map) iq_map <= set_data[7:0];
            if (hit_dir) het_dir <= set_data[0];
            off_wr_i <= hit_off_i;
            off_wr_q <= hit_off_q;
            if (hit_off_i || hit_off_q) off_data <= set_data;
        end
    end

    // Stage 1: mapping
    logic signed [WIDTH-1:0] m_i, m_q;
    logic signed [WIDTH-1:0] s1_i, s1_q;
    logic [WIDTH-1:0] raw1_i, raw1_q;
    logic byp1, dcv1, dir1;
    logic [1:0] ph1;

    always_comb begin
        m_i = iq_map[IQ_SWAP] ? in_q : in_i;
        m_q = iq_map[IQ_SWAP] ? in_i : in_q;
        if (iq_map[IQ_REAL])  m_q = '0;
        if (iq_map[IQ_INV_Q]) m_q = neg_w(m_q);
        if (iq_map[IQ_INV_I]) m_i = neg_w(m_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_i   <= '0;
            s1_q   <= '0;
            raw1_i <= '0;
            raw1_q <= '0;
            byp1   <= 1'b0;
            dcv1   <= 1'b0;
            dir1   <= 1'b0;
            ph1    <= '0;
        end else if (stage_en[0]) begin
            s1_i   <= m_i;
            s1_q   <= m_q;
            raw1_i <= in_i;
            raw1_q <= in_q;
            byp1   <= iq_map[IQ_BYPASS];
            dcv1   <= iq_map[IQ_DOWNCONVERT];
            dir1   <= het_dir;
            ph1    <= phase;
        end
    end

    // Stage 2: DC offset
    logic signed [WIDTH-1:0] y_i, y_q;
    logic signed [WIDTH-1:0] s2_i, s2_q;
    logic [WIDTH-1:0] raw2_i, raw2_q;
    logic byp2, dcv2, dir2;
    logic [1:0] ph2;

    always_comb begin
        y_i = dc_out(s1_i, acc_i);
        y_q = dc_out(s1_q, acc_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fixed_i <= 1'b1;
            fixed_q <= 1'b1;
            acc_i   <= '0;
            acc_q   <= '0;
        end else begin
            if (off_wr_i) fixed_i <= off_data[OFF_FIXED];
            if (off_wr_q) fixed_q <= off_data[OFF_FIXED];
            if (off_wr_i && off_data[OFF_SET])
                acc_i <= {off_data[WIDTH-1:0], {DC_SHIFT{1'b0}}};
            else if (stage_en[1] && !fixed_i)
                acc_i <= acc_add(acc_i, y_i);
            if (off_wr_q && off_data[OFF_SET])
                acc_q <= {off_data[WIDTH-1:0], {DC_SHIFT{1'b0}}};
            else if (stage_en[1] && !fixed_q)
                acc_q <= acc_add(acc_q, y_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_i   <= '0;
            s2_q   <= '0;
            raw2_i <= '0;
            raw2_q <= '0;
            byp2   <= 1'b0;
            dcv2   <= 1'b0;
            dir2   <= 1'b0;
            ph2    <= '0;
        end else if (stage_en[1]) begin
            s2_i   <= y_i;
            s2_q   <= y_q;
            raw2_i <= raw1_i;
            raw2_q <= raw1_q;
            byp2   <= byp1;
            dcv2   <= dcv1;
            dir2   <= dir1;
            ph2    <= ph1;
        end
    end

    // Stage 3: Fs/4 rotation; the negative direction runs the phase backwards
    logic [1:0] pe;
    logic signed [WIDTH-1:0] rot_i, rot_q;

    always_comb begin
        pe    = dir2 ? 2'(2'd0 - ph2) : ph2;
        rot_i = s2_i;
        rot_q = s2_q;
        if (dcv2) begin
            case (pe)
                2'd1: begin rot_i = neg_w(s2_q); rot_q = s2_i;        end
                2'd2: begin rot_i = neg_w(s2_i); rot_q = neg_w(s2_q); end
                2'd3: begin rot_i = s2_q;        rot_q = neg_w(s2_i); end
                default: ;
            endcase
        end
        if (byp2) begin
            rot_i = raw2_i;
            rot_q = raw2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_i <= '0;
            out_q <= '0;
        end else if (stage_en[2]) begin
            out_i <= rot_i;
            out_q <= rot_q;
        end
    end

endmodule

// File: rtl/rx_frontend_mc.sv
// Multichannel RX frontend top: shared Fs/4 phase counter, valid pipeline and
// one processing channel per lane.
module rx_frontend_mc
    import rx_frontend_mc_pkg::*;
#(
    parameter int unsigned NUM_CHAN  = 2,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DC_SHIFT  = 20,
    parameter int unsigned SR_BASE   = 0,
    parameter int unsigned SR_STRIDE = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sync_in,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic                      in_tvalid,
    input  logic [NUM_CHAN*WIDTH-1:0] in_i,
    input  logic [NUM_CHAN*WIDTH-1:0] in_q,
    output logic                      out_tvalid,
    output logic [NUM_CHAN*WIDTH-1:0] out_i,
    output logic [NUM_CHAN*WIDTH-1:0] out_q
);

    logic [1:0] phase, phase_use;
    logic [2:0] vpipe;
    logic [2:0] stage_en;

    // A sync in the same cycle as a valid sample gives that sample phase 0.
    always_comb begin
        phase_use = sync_in ? 2'd0 : phase;
        stage_en  = {vpipe[1], vpipe[0], in_tvalid};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            vpipe <= '0;
        end else begin
            if (in_tvalid) phase <= phase_use + 2'd1;
            else if (sync_in) phase <= '0;
            vpipe <= {vpipe[1:0], in_tvalid};
        end
    end

    assign out_tvalid = vpipe[2];

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        rx_frontend_mc_chan #(
            .WIDTH     (WIDTH),
            .DC_SHIFT  (DC_SHIFT),
            .SR_BASE   (SR_BASE),
            .SR_STRIDE (SR_STRIDE),
            .CHAN      (c)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .set_stb  (set_stb),
            .set_addr (set_addr),
            .set_data (set_data),
            .stage_en (stage_en),
            .phase    (phase_use),
            .in_i     (in_i[c*WIDTH +: WIDTH]),
            .in_q     (in_q[c*WIDTH +: WIDTH]),
            .out_i    (out_i[c*WIDTH +: WIDTH]),
            .out_q    (out_q[c*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_rx_frontend_mc.sv
// Self-checking bench for rx_frontend_mc: directed cases plus randomized traffic
// compared against a behavioural model of the frontend.
module tb_rx_frontend_mc;

    localparam int NC  = 2;
    localparam int W   = 16;
    localparam int DS  = 4;
    localparam int STR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, sync_in, set_stb, in_tvalid, out_tvalid;
    logic [7:0]    set_addr;
    logic [31:0]   set_data;
    logic [NC*W-1:0] in_i, in_q, out_i, out_q;

    rx_frontend_mc #(
        .NUM_CHAN  (NC),
        .WIDTH     (W),
        .DC_SHIFT  (DS),
        .SR_BASE   (0),
        .SR_STRIDE (STR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_in    (sync_in),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .in_tvalid  (in_tvalid),
        .in_i       (in_i),
        .in_q       (in_q),
        .out_tvalid (out_tvalid),
        .out_i      (out_i),
        .out_q      (out_q)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [7:0] iqmap[NC];
    bit         fix_i[NC], fix_q[NC], hdir[NC];
    longint     acc_i[NC], acc_q[NC];
    int         phase;
    int         xi[NC], xq[NC];

    typedef struct {
        logic [NC*W-1:0] i;
        logic [NC*W-1:0] q;
    } exp_t;
    exp_t expq[$];
    bit [2:0] hist;
    int obs_i[$], obs_q[$];

    bit          wr_stb;
    int          wr_addr;
    logic [31:0] wr_data;

    function automatic longint clamp(input longint x, input int bits);
        longint hi;
        hi = (longint'(1) << (bits - 1)) - 1;
        if (x > hi) return hi;
        if (x < -hi - 1) return -hi - 1;
        return x;
    endfunction

    function automatic int sneg(input int x);
        return int'(clamp(-longint'(x), W));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            iqmap[c] = '0;
            fix_i[c] = 1'b1;
            fix_q[c] = 1'b1;
            hdir[c]  = 1'b0;
            acc_i[c] = 0;
            acc_q[c] = 0;
        end
        phase = 0;
        expq.delete();
    endtask

    task automatic model_write(input int addr, input logic [31:0] d);
        int c, k;
        c = addr / STR;
        k = addr % STR;
        if (c >= NC) return;
        case (k)
            0: iqmap[c] = d[7:0];
            1: begin
                fix_i[c] = d[31];
                if (d[30]) acc_i[c] = longint'($signed(d[W-1:0])) * (longint'(1) << DS);
            end
            2: begin
                fix_q[c] = d[31];
                if (d[30]) acc_q[c] = longint'($signed(d[W-1:0])) * (longint'(1) << DS);
            end
            3: hdir[c] = d[0];
            default: ;
        endcase
    endtask

    task automatic model_sample(input int ph, output exp_t e);
        int a, b, t, yi, yq, ri, rq, pe;
        for (int c = 0; c < NC; c++) begin
            a = xi[c];
            b = xq[c];
            if (iqmap[c][0]) begin t = a; a = b; b = t; end
            if (iqmap[c][1]) b = 0;
            if (iqmap[c][2]) b = sneg(b);
            if (iqmap[c][3]) a = sneg(a);
            yi = int'(clamp(longint'(a) - (acc_i[c] >>> DS), W));
            yq = int'(clamp(longint'(b) - (acc_q[c] >>> DS), W));
            if (!fix_i[c]) acc_i[c] = clamp(acc_i[c] + yi, W + DS);
            if (!fix_q[c]) acc_q[c] = clamp(acc_q[c] + yq, W + DS);
            pe = hdir[c] ? (4 - ph) % 4 : ph;
            case (pe)
                1:       begin ri = sneg(yq); rq = yi;       end
                2:       begin ri = sneg(yi); rq = sneg(yq); end
                3:       begin ri = yq;       rq = sneg(yi); end
                default: begin ri = yi;       rq = yq;       end
            endcase
            if (!iqmap[c][4]) begin ri = yi; rq = yq; end
            if (iqmap[c][7]) begin ri = xi[c]; rq = xq[c]; end
            e.i[c*W +: W] = W'(ri);
            e.q[c*W +: W] = W'(rq);
        end
    endtask

    task automatic step(input bit v, input bit s);
        exp_t e;
        @(negedge clk);
        in_tvalid = v;
        sync_in   = s;
        set_stb   = wr_stb;
        set_addr  = 8'(wr_addr);
        set_data  = wr_data;
        for (int c = 0; c < NC; c++) begin
            in_i[c*W +: W] = W'(xi[c]);
            in_q[c*W +: W] = W'(xq[c]);
        end
        @(posedge clk);
        if (reset) begin
            model_reset();
            hist = '0;
        end else begin
            hist = {hist[1:0], v};
            if (v) begin
                int ph;
                ph = s ? 0 : phase;
                model_sample(ph, e);
                expq.push_back(e);
                phase = (ph + 1) % 4;
            end else if (s) begin
                phase = 0;
            end
            if (wr_stb) model_write(wr_addr, wr_data);
        end
        #1;
        if (reset) begin
            check("rst_vld", 64'(out_tvalid), 64'd0);
            check("rst_i", 64'(out_i), 64'd0);
            check("rst_q", 64'(out_q), 64'd0);
        end else begin
            check("vld", 64'(out_tvalid), 64'(hist[2]));
            if (hist[2]) begin
                e = expq.pop_front();
                check("out_i", 64'(out_i), 64'(e.i));
                check("out_q", 64'(out_q), 64'(e.q));
                obs_i.push_back(int'($signed(out_i[W-1:0])));
                obs_q.push_back(int'($signed(out_q[W-1:0])));
            end
        end
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        wr_stb  = 1'b1;
        wr_addr = addr;
        wr_data = d;
        step(1'b0, 1'b0);
        wr_stb  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic set_in(input int c, input int i, input int q);
        xi[c] = i;
        xq[c] = q;
    endtask

    task automatic held0(input string tag, input int ei, input int eq);
        check({tag, "_i"}, 64'(int'($signed(out_i[W-1:0]))), 64'(ei));
        check({tag, "_q"}, 64'(int'($signed(out_q[W-1:0]))), 64'(eq));
    endtask

    task automatic held1(input string tag, input int ei, input int eq);
        check({tag, "_i1"}, 64'(int'($signed(out_i[2*W-1:W]))), 64'(ei));
        check({tag, "_q1"}, 64'(int'($signed(out_q[2*W-1:W]))), 64'(eq));
    endtask

    function automatic int pick();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return -32768;
            1:       return 32767;
            default: return int'($signed(r));
        endcase
    endfunction

    task automatic rot_run(input bit dir, input bit sync_with_valid);
        int ti[4], tq[4];
        ti = '{1000, 0, -1000, 0};
        tq = dir ? '{0, -1000, 0, 1000} : '{0, 1000, 0, -1000};
        wr(3, 32'(dir));
        set_in(0, 1000, 0);
        obs_i.delete();
        obs_q.delete();
        if (!sync_with_valid) step(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, sync_with_valid && k == 0);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
        end
        drain(3);
        check("rot_cnt", 64'(obs_i.size()), 64'd8);
        for (int k = 0; k < 8 && k < obs_i.size(); k++) begin
            check($sformatf("rot%0d_%0d_i", dir, k), 64'(obs_i[k]), 64'(ti[k % 4]));
            check($sformatf("rot%0d_%0d_q", dir, k), 64'(obs_q[k]), 64'(tq[k % 4]));
        end
    endtask

    initial begin
        int last;
        reset = 1'b1; sync_in = 1'b0; set_stb = 1'b0; in_tvalid = 1'b0;
        set_addr = '0; set_data = '0; in_i = '0; in_q = '0;
        wr_stb = 1'b0; wr_addr = 0; wr_data = '0;
        hist = '0;
        for (int c = 0; c < NC; c++) set_in(c, 0, 0);
        model_reset();

        // valid samples during reset must not emerge
        for (int k = 0; k < 4; k++) begin
            set_in(0, pick(), pick());
            step(1'b1, 1'b0);
        end
        reset = 1'b0;
        set_in(0, 0, 0);
        drain(3);

        set_in(0, 1000, 2000); set_in(1, -5, 7);
        step(1'b1, 1'b0); drain(3);
        held0("pass", 1000, 2000);

        wr(0, 32'h09); set_in(0, 100, -200);
        step(1'b1, 1'b0); drain(3);
        held0("swap_inv", 200, 100);

        wr(0, 32'h08); set_in(0, -32768, 5);
        step(1'b1, 1'b0); drain(3);
        held0("inv_sat", 32767, 5);

        wr(0, 32'h02); set_in(0, 123, 456);
        step(1'b1, 1'b0); drain(3);
        held0("real", 123, 0);

        wr(0, 32'h00); wr(8, 32'h01);
        set_in(0, 11, 22); set_in(1, 33, 44);
        step(1'b1, 1'b0); drain(3);
        held0("iso", 11, 22);
        held1("iso", 44, 33);

        // out-of-range channel and unmapped offset
        wr(16, 32'h9F); wr(5, 32'h01);
        set_in(0, 55, 66); set_in(1, 77, 88);
        step(1'b1, 1'b0); drain(3);
        held0("nochan", 55, 66);
        held1("nochan", 88, 77);

        wr(8, 32'h00); wr(0, 32'h10);
        rot_run(1'b0, 1'b0);
        rot_run(1'b1, 1'b1);

        wr(0, 32'h00); wr(1, 32'hC000_01F4);
        set_in(0, 1500, 0);
        step(1'b1, 1'b0); drain(3);
        held0("dc_fix", 1000, 0);

        wr(1, 32'h0000_0000);
        obs_i.delete(); obs_q.delete();
        repeat (500) step(1'b1, 1'b0);
        drain(3);
        last = (obs_i.size() > 0) ? obs_i[obs_i.size() - 1] : 99999;
        check("dc_track", 64'(last >= -1 && last <= 1), 64'd1);
        wr(1, 32'h8000_0000);

        wr(0, 32'h90); set_in(0, -7, 9);
        step(1'b1, 1'b0); drain(3);
        held0("bypass", -7, 9);

        // reset with samples in flight
        wr(0, 32'h00);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        reset = 1'b0;
        drain(4);

        for (int n = 0; n < 800; n++) begin
            for (int c = 0; c < NC; c++) set_in(c, pick(), pick());
            if ($urandom_range(0, 9) == 0) begin
                wr_stb  = 1'b1;
                wr_addr = $urandom_range(0, 23);
                wr_data = $urandom;
            end else begin
                wr_stb = 1'b0;
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
        wr_stb = 1'b0;
        drain(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
